reorder_queue: RTL and testbench

REORDER_QUEUE -- requirements
Module: reorder_queue

---
 rtl/reorder_queue_pkg.sv | 30 +++
 rtl/rob_wb_arbiter.sv | 32 +++
 rtl/reorder_queue.sv | 156 +++++++++++++++
 tb/tb_reorder_queue.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_queue_pkg.sv
// Shared reorder-queue definitions: entry type codes, default sizing and the
// per-entry payload layout used by the decoder, RS, LSB and the queue itself.
package reorder_queue_pkg;

  localparam int ROB_WIDTH_BIT_DEFAULT = 3;
  localparam int ROB_TYPE_W            = 2;

  typedef enum logic [ROB_TYPE_W-1:0] {
    TYPE_ALU    = 2'b00,
    TYPE_LOAD   = 2'b01,
    TYPE_STORE  = 2'b10,
    TYPE_BRANCH = 2'b11
  } rob_type_e;

  typedef struct packed {
    rob_type_e   rtype;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred_taken;
    logic        taken;
    logic [31:0] target;
    logic [31:0] val;
  } rob_entry_t;

  // Width of a writeback channel index; never zero so a single port still works.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rob_wb_arbiter.sv
// Per-entry writeback resolution: which channel (lowest index wins) targets
// each queue entry this cycle. Shared by the entry update and query forwarding.
module rob_wb_arbiter
  import reorder_queue_pkg::*;
#(
  parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEFAULT,
  parameter int WB_PORTS      = 2,
  parameter int CH_W          = sel_width(WB_PORTS)
) (
  input  logic [WB_PORTS-1:0]               wb_valid,
  input  logic [WB_PORTS*ROB_WIDTH_BIT-1:0] wb_id,
  output logic [(1<<ROB_WIDTH_BIT)-1:0]     hit,
  output logic [CH_W-1:0]                   sel [1<<ROB_WIDTH_BIT]
);

  // NOTE: every output gets a default before the loops so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hit = '0;
    for (int e = 0; e < (1 << ROB_WIDTH_BIT); e++) begin
      sel[e] = '0;
      // Scan from the highest channel down so the lowest matching one lands last.
      for (int k = WB_PORTS - 1; k >= 0; k--) begin
        if (wb_valid[k] && wb_id[k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT] == ROB_WIDTH_BIT'(e)) begin
          hit[e] = 1'b1;
          sel[e] = CH_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/reorder_queue.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback with
// operand forwarding, in-order single-entry commit and mispredict flush.
module reorder_queue
  import reorder_queue_pkg::*;
#(
  parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEFAULT,
  parameter int WB_PORTS      = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              rdy_in,
  input  logic                              alloc_valid,
  input  logic [1:0]                        alloc_type,
  input  logic [4:0]                        alloc_rd,
  input  logic [31:0]                       alloc_pc,
  input  logic                              alloc_pred_taken,
  output logic [ROB_WIDTH_BIT-1:0]          alloc_id,
  output logic                              full,
  input  logic [WB_PORTS-1:0]               wb_valid,
  input  logic [WB_PORTS*ROB_WIDTH_BIT-1:0] wb_id,
  input  logic [WB_PORTS*32-1:0]            wb_val,
  input  logic [WB_PORTS-1:0]               wb_taken,
  input  logic [WB_PORTS*32-1:0]            wb_target,
  input  logic [ROB_WIDTH_BIT-1:0]          query_id1,
  input  logic [ROB_WIDTH_BIT-1:0]          query_id2,
  output logic                              query_ready1,
  output logic                              query_ready2,
  output logic [31:0]                       query_val1,
  output logic [31:0]                       query_val2,
  output logic                              commit_valid,
  output logic [4:0]                        commit_rd,
  output logic [31:0]                       commit_val,
  output logic [ROB_WIDTH_BIT-1:0]          commit_id,
  output logic                              commit_store,
  output logic                              clear_flag,
  output logic [31:0]                       pc_fact
);

  localparam int ENTRIES = 1 << ROB_WIDTH_BIT;
  localparam int CNT_W   = ROB_WIDTH_BIT + 1;
  localparam int CH_W    = sel_width(WB_PORTS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

  rob_entry_t               ent [ENTRIES];
  rob_entry_t               head_ent;
  logic [ENTRIES-1:0]       busy, ready, wb_hit;
  logic [CH_W-1:0]          wb_sel [ENTRIES];
  logic [31:0]              wb_val_a [WB_PORTS];
  logic [31:0]              wb_target_a [WB_PORTS];
  logic [ROB_WIDTH_BIT-1:0] head, tail;
  logic [CNT_W-1:0]         count;
  logic                     accept, do_alloc, do_commit, mispredict;

  always_comb begin
    for (int k = 0; k < WB_PORTS; k++) begin
      wb_val_a[k]    = wb_val[k*32 +: 32];
      wb_target_a[k] = wb_target[k*32 +: 32];
    end
  end

  rob_wb_arbiter #(
    .ROB_WIDTH_BIT (ROB_WIDTH_BIT),
    .WB_PORTS      (WB_PORTS),
    .CH_W          (CH_W)
  ) u_arbiter (
    .wb_valid (wb_valid),
    .wb_id    (wb_id),
    .hit      (wb_hit),
    .sel      (wb_sel)
  );

  // Inputs are dropped both while stalled and during the flush pulse.
  assign accept     = rdy_in && !clear_flag;
  assign full       = (count == FULL_CNT);
  assign alloc_id   = tail;
  assign head_ent   = ent[head];
  assign do_alloc   = accept && alloc_valid && !full;
  assign do_commit  = accept && busy[head] && ready[head];
  assign mispredict = do_commit && head_ent.rtype == TYPE_BRANCH &&
                      head_ent.taken != head_ent.pred_taken;

  assign query_ready1 = ready[query_id1] || wb_hit[query_id1];
  assign query_ready2 = ready[query_id2] || wb_hit[query_id2];
  assign query_val1   = wb_hit[query_id1] ? wb_val_a[wb_sel[query_id1]] : ent[query_id1].val;
  assign query_val2   = wb_hit[query_id2] ? wb_val_a[wb_sel[query_id2]] : ent[query_id2].val;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in || mispredict) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      ready <= '0;
    end else if (accept) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (wb_hit[e] && busy[e]) ready[e] <= 1'b1;
      end
      if (do_commit) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (do_alloc) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + 1'b1;
      end
      count <= count + CNT_W'(do_alloc) - CNT_W'(do_commit);
    end
  end

  // NOTE: the payload array has no reset; busy/ready gate every use of it,
  // so clearing it would only cost reset fan-out.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (wb_hit[e] && busy[e]) begin
          ent[e].val    <= wb_val_a[wb_sel[e]];
          ent[e].taken  <= wb_taken[wb_sel[e]];
          ent[e].target <= wb_target_a[wb_sel[e]];
        end
      end
      if (do_alloc) begin
        ent[tail].rtype      <= rob_type_e'(alloc_type);
        ent[tail].rd         <= alloc_rd;
        ent[tail].pc         <= alloc_pc;
        ent[tail].pred_taken <= alloc_pred_taken;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      commit_valid <= 1'b0;
      commit_store <= 1'b0;
      clear_flag   <= 1'b0;
      commit_rd    <= '0;
      commit_val   <= '0;
      commit_id    <= '0;
      pc_fact      <= '0;
    end else begin
      commit_valid <= do_commit && head_ent.rd != 5'd0 && head_ent.rtype != TYPE_STORE;
      commit_store <= do_commit && head_ent.rtype == TYPE_STORE;
      clear_flag   <= mispredict;
      if (do_commit) begin
        commit_rd  <= head_ent.rd;
        commit_val <= head_ent.val;
        commit_id  <= head;
      end
      if (mispredict) pc_fact <= head_ent.taken ? head_ent.target : head_ent.pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_reorder_queue.sv
// Directed and randomized checks of reorder_queue against an in-order
// queue model of the instruction window.
module tb_reorder_queue;

  localparam int RW = 3;
  localparam int WP = 2;
  localparam int N  = 8;
  localparam logic [1:0] T_ALU = 2'b00, T_STORE = 2'b10, T_BRANCH = 2'b11;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, alloc_valid, alloc_pred_taken;
  logic [1:0]        alloc_type;
  logic [4:0]        alloc_rd;
  logic [31:0]       alloc_pc;
  logic [RW-1:0]     alloc_id;
  logic              full;
  logic [WP-1:0]     wb_valid, wb_taken;
  logic [WP*RW-1:0]  wb_id;
  logic [WP*32-1:0]  wb_val, wb_target;
  logic [RW-1:0]     query_id1, query_id2;
  logic              query_ready1, query_ready2;
  logic [31:0]       query_val1, query_val2;
  logic              commit_valid, commit_store, clear_flag;
  logic [4:0]        commit_rd;
  logic [31:0]       commit_val, pc_fact;
  logic [RW-1:0]     commit_id;

  reorder_queue #(.ROB_WIDTH_BIT(RW), .WB_PORTS(WP)) dut (
    .clk_in (clk_in), .rst_in (rst_in), .rdy_in (rdy_in),
    .alloc_valid (alloc_valid), .alloc_type (alloc_type), .alloc_rd (alloc_rd),
    .alloc_pc (alloc_pc), .alloc_pred_taken (alloc_pred_taken),
    .alloc_id (alloc_id), .full (full),
    .wb_valid (wb_valid), .wb_id (wb_id), .wb_val (wb_val),
    .wb_taken (wb_taken), .wb_target (wb_target),
    .query_id1 (query_id1), .query_id2 (query_id2),
    .query_ready1 (query_ready1), .query_ready2 (query_ready2),
    .query_val1 (query_val1), .query_val2 (query_val2),
    .commit_valid (commit_valid), .commit_rd (commit_rd), .commit_val (commit_val),
    .commit_id (commit_id), .commit_store (commit_store),
    .clear_flag (clear_flag), .pc_fact (pc_fact)
  );

  always #5 clk_in = ~clk_in;

  // Model: the in-flight window in program order, each with its tag.
  typedef struct {
    int          id;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic        rdy;
    logic [31:0] val;
    logic        taken;
    logic [31:0] tgt;
  } ment_t;

  ment_t mq[$];
  int    m_head  = 0;
  bit    m_clear = 0;
  int    checks  = 0;
  int    errors  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rdy_in = 1'b1; alloc_valid = 1'b0; alloc_type = T_ALU; alloc_rd = '0;
    alloc_pc = '0; alloc_pred_taken = 1'b0;
    wb_valid = '0; wb_id = '0; wb_val = '0; wb_taken = '0; wb_target = '0;
    query_id1 = '0; query_id2 = '0;
  endtask

  task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc, input logic pred);
    alloc_valid = 1'b1; alloc_type = t; alloc_rd = rd; alloc_pc = pc; alloc_pred_taken = pred;
  endtask

  task automatic set_wb(input int k, input int id, input logic [31:0] v, input logic tk, input logic [31:0] tg);
    wb_valid[k] = 1'b1; wb_id[k*RW +: RW] = RW'(id); wb_val[k*32 +: 32] = v;
    wb_taken[k] = tk; wb_target[k*32 +: 32] = tg;
  endtask

  function automatic void model_query(input logic [RW-1:0] qid, output logic rdy, output logic [31:0] v);
    rdy = 1'b0; v = '0;
    foreach (mq[i]) if (mq[i].id == int'(qid) && mq[i].rdy) begin rdy = 1'b1; v = mq[i].val; end
    for (int k = WP - 1; k >= 0; k--)
      if (wb_valid[k] && wb_id[k*RW +: RW] == qid) begin rdy = 1'b1; v = wb_val[k*32 +: 32]; end
  endfunction

  // One clock: check combinational outputs, advance the model, clock, check registers.
  task automatic cycle();
    logic        qr, e_cv, e_cs, e_cf;
    logic [31:0] qv, e_pc;
    logic [RW-1:0] wid;
    int          sz, nid;
    bit          commit, mis, dup;
    ment_t       h;
    #1;
    sz  = mq.size();
    nid = (m_head + sz) % N;
    check("full", full, 32'(sz == N));
    check("alloc_id", alloc_id, nid[RW-1:0]);
    model_query(query_id1, qr, qv);
    check("query_ready1", query_ready1, qr);
    if (qr) check("query_val1", query_val1, qv);
    model_query(query_id2, qr, qv);
    check("query_ready2", query_ready2, qr);
    if (qr) check("query_val2", query_val2, qv);
    e_cv = 0; e_cs = 0; e_cf = 0; e_pc = '0; commit = 0; mis = 0;
    if (rdy_in && !m_clear) begin
      commit = (sz > 0) && mq[0].rdy;
      if (commit) h = mq[0];
      for (int k = 0; k < WP; k++) begin
        if (wb_valid[k]) begin
          wid = wb_id[k*RW +: RW];
          dup = 0;
          for (int j = 0; j < k; j++) if (wb_valid[j] && wb_id[j*RW +: RW] == wid) dup = 1;
          if (!dup) foreach (mq[i]) if (mq[i].id == int'(wid)) begin
            mq[i].rdy = 1'b1; mq[i].val = wb_val[k*32 +: 32];
            mq[i].taken = wb_taken[k]; mq[i].tgt = wb_target[k*32 +: 32];
          end
        end
      end
      if (commit) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % N;
        e_cv = (h.rd != 0) && (h.typ != T_STORE);
        e_cs = (h.typ == T_STORE);
        mis  = (h.typ == T_BRANCH) && (h.taken != h.pred);
        if (mis) begin
          e_cf = 1; e_pc = h.taken ? h.tgt : h.pc + 32'd4;
          mq.delete(); m_head = 0;
        end
      end
      if (alloc_valid && sz < N && !mis)
        mq.push_back('{id: nid, typ: alloc_type, rd: alloc_rd, pc: alloc_pc,
                       pred: alloc_pred_taken, rdy: 1'b0, val: '0, taken: 1'b0, tgt: '0});
    end
    m_clear = e_cf;
    @(posedge clk_in); #1;
    check("commit_valid", commit_valid, e_cv);
    check("commit_store", commit_store, e_cs);
    check("clear_flag", clear_flag, e_cf);
    if (e_cv || e_cs) begin
      check("commit_rd", commit_rd, h.rd);
      check("commit_val", commit_val, h.val);
      check("commit_id", commit_id, h.id[RW-1:0]);
    end
    if (e_cf) check("pc_fact", pc_fact, e_pc);
  endtask

  initial begin
    // Reset with an allocation pending: reset must win.
    idle();
    rst_in = 1'b1;
    alloc(T_ALU, 5'd3, 32'h40, 1'b0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_store", commit_store, 0);
    check("rst_clear_flag", clear_flag, 0);
    check("rst_commit_rd", commit_rd, 0);
    check("rst_commit_val", commit_val, 0);
    check("rst_commit_id", commit_id, 0);
    check("rst_pc_fact", pc_fact, 0);
    check("rst_full", full, 0);
    check("rst_alloc_id", alloc_id, 0);

    // Fill the queue, then a ninth push is refused.
    for (int i = 1; i <= 8; i++) begin
      idle(); alloc(T_ALU, 5'(i), 32'h1000 + 32'(i * 4), 1'b0); cycle();
    end
    #1;
    check("fill_full", full, 1);
    check("fill_alloc_id", alloc_id, 0);
    idle(); alloc(T_ALU, 5'd9, 32'h1024, 1'b0); cycle();

    // Out-of-order writebacks, in-order commits.
    idle(); set_wb(0, 2, 32'h20, 1'b0, '0); cycle();
    idle(); set_wb(0, 1, 32'h10, 1'b0, '0); cycle();
    idle(); set_wb(0, 0, 32'h00, 1'b0, '0); cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); cycle();
      check("inorder_commit_id", commit_id, RW'(i));
      check("inorder_commit_valid", commit_valid, 1);
    end

    // Same-id writeback on both channels: channel 0 wins, forwarded at once.
    idle(); query_id1 = 3;
    set_wb(0, 3, 32'hAAAA, 1'b0, '0); set_wb(1, 3, 32'hBBBB, 1'b0, '0);
    #1;
    check("fwd_ready", query_ready1, 1);
    check("fwd_val", query_val1, 32'hAAAA);
    cycle();
    idle(); cycle();
    check("prio_commit_val", commit_val, 32'hAAAA);
    check("prio_commit_id", commit_id, 3);

    // Full queue with a ready head: commit now, allocation only next cycle.
    for (int i = 0; i < 4; i++) begin
      idle(); alloc(T_ALU, 5'(10 + i), 32'h2000 + 32'(i * 4), 1'b0); cycle();
    end
    idle(); set_wb(0, 4, 32'h44, 1'b0, '0); cycle();
    idle(); alloc(T_ALU, 5'd20, 32'h2010, 1'b0); cycle();
    check("fullcommit_id", commit_id, 4);
    #1;
    check("fullcommit_not_full", full, 0);
    check("fullcommit_alloc_id", alloc_id, 4);
    cycle();

    // Stall with a ready head; inputs during the stall are ignored.
    idle(); set_wb(0, 5, 32'h55, 1'b0, '0); cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); rdy_in = 1'b0;
      alloc(T_STORE, 5'd0, 32'h3000, 1'b0); set_wb(0, 6, 32'h66, 1'b0, '0);
      cycle();
      check("stall_no_commit", commit_valid, 0);
    end
    idle(); cycle();
    check("stall_resume_valid", commit_valid, 1);
    check("stall_resume_id", commit_id, 5);
    idle(); query_id1 = 6; #1;
    check("stall_wb_dropped", query_ready1, 0);

    // Drain the rest.
    for (int i = 0; i < 7; i++) begin
      idle(); set_wb(i % 2, (6 + i) % N, 32'h100 + 32'(i), 1'b0, '0); cycle();
    end
    repeat (3) begin idle(); cycle(); end
    #1;
    check("drain_alloc_id", alloc_id, 5);

    // Mispredicted branch flushes younger work.
    idle(); alloc(T_BRANCH, 5'd0, 32'h100, 1'b0); cycle();
    idle(); alloc(T_ALU, 5'd7, 32'h104, 1'b0); cycle();
    idle(); alloc(T_ALU, 5'd8, 32'h108, 1'b0); cycle();
    idle(); set_wb(0, 6, 32'h77, 1'b0, '0); set_wb(1, 5, 32'h0, 1'b1, 32'h200); cycle();
    idle(); cycle();
    check("mispredict_clear", clear_flag, 1);
    check("mispredict_pc_fact", pc_fact, 32'h200);
    idle(); alloc(T_ALU, 5'd9, 32'h10C, 1'b0); set_wb(0, 7, 32'h88, 1'b0, '0);
    #1;
    check("flush_alloc_id", alloc_id, 0);
    check("flush_full", full, 0);
    cycle();
    check("flush_pulse_end", clear_flag, 0);
    idle(); #1;
    check("flush_alloc_dropped", alloc_id, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      idle();
      rdy_in = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) != 0)
        alloc(($urandom_range(0, 7) == 0) ? T_BRANCH : 2'($urandom_range(0, 2)),
              5'($urandom_range(0, 31)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
      for (int k = 0; k < WP; k++)
        if ($urandom_range(0, 2) != 0)
          set_wb(k, int'($urandom_range(0, N - 1)), $urandom, 1'($urandom_range(0, 1)), $urandom);
      query_id1 = RW'($urandom_range(0, N - 1));
      query_id2 = RW'($urandom_range(0, N - 1));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
